dma_axis_rr_arbiter: RTL and testbench

Parametrised N-channel AXI4-Stream packet arbiter for the DMA datapath. It merges `C_NUM_CH` slave streams into one master stream with packet-granular round-robin arbitration and a registered output stage. It can optionally tag the source channel into TUSER and keeps a wrapping packet counter per channel. It sits between the per-queue DMA engines and the shared 256-bit egress stream toward the PCIe/host path.

---
 rtl/dma_axis_pkg.sv | 31 +++
 rtl/dma_axis_rr_arbiter_if.sv | 36 +++
 rtl/dma_axis_rr_pick.sv | 30 +++
 rtl/dma_axis_rr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dma_axis_rr_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_axis_pkg.sv
// Shared types and helpers for the DMA AXI4-Stream round-robin arbiter.
package dma_axis_pkg;

    // Arbiter FSM: IDLE arbitrates, BUSY streams the granted packet.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Width of each per-channel completed-packet counter.
    localparam int CNT_WIDTH = 32;

    // Default sideband width and default position of the channel tag in TUSER.
    localparam int TUSER_WIDTH_DEFAULT = 128;
    localparam int TAG_LSB_DEFAULT     = 120;

    // Ceiling log2, minimum result 0; used to size channel index fields.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dma_axis_rr_arbiter_if.sv
// Bundle of the N slave streams and the merged master stream of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding fabric
// (DMA engines on the channel side, egress path on the merged side).
interface dma_axis_rr_arbiter_if #(
    parameter int C_DATA_WIDTH  = 256,
    parameter int C_TUSER_WIDTH = 128,
    parameter int C_NUM_CH      = 4
);
    logic [C_NUM_CH*C_DATA_WIDTH-1:0]     S_AXIS_TDATA;
    logic [C_NUM_CH*(C_DATA_WIDTH/8)-1:0] S_AXIS_TSTRB;
    logic [C_NUM_CH*C_TUSER_WIDTH-1:0]    S_AXIS_TUSER;
    logic [C_NUM_CH-1:0]                  S_AXIS_TVALID;
    logic [C_NUM_CH-1:0]                  S_AXIS_TLAST;
    logic [C_NUM_CH-1:0]                  S_AXIS_TREADY;

    logic [C_DATA_WIDTH-1:0]              M_AXIS_TDATA;
    logic [C_DATA_WIDTH/8-1:0]            M_AXIS_TSTRB;
    logic [C_TUSER_WIDTH-1:0]             M_AXIS_TUSER;
    logic                                 M_AXIS_TVALID;
    logic                                 M_AXIS_TLAST;
    logic                                 M_AXIS_TREADY;

    modport slave (
        input  S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TVALID, S_AXIS_TLAST,
        output S_AXIS_TREADY,
        output M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TVALID, M_AXIS_TLAST,
        input  M_AXIS_TREADY
    );

    modport master (
        output S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TVALID, S_AXIS_TLAST,
        input  S_AXIS_TREADY,
        input  M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TVALID, M_AXIS_TLAST,
        output M_AXIS_TREADY
    );
endinterface

// File: rtl/dma_axis_rr_pick.sv
// Combinational round-robin selector: finds the first set request starting
// one past the previous winner and wrapping modulo the channel count.
module dma_axis_rr_pick #(
    parameter int C_NUM_CH = 4,
    parameter int CHW      = 2
) (
    input  logic [C_NUM_CH-1:0] req,
    input  logic [CHW-1:0]      last_gnt,
    output logic                valid,
    output logic [CHW-1:0]      idx
);

    // Priority scan from last_gnt+1; the previous winner is checked last.
    always_comb begin
        int             sum;
        logic [CHW-1:0] cand;
        logic           hit;
        valid = 1'b0;
        idx   = {CHW{1'b0}};
        for (int k = 1; k <= C_NUM_CH; k++) begin
            sum   = int'(last_gnt) + k;
            sum   = (sum >= C_NUM_CH) ? (sum - C_NUM_CH) : sum;
            cand  = CHW'(sum);
            hit   = ~valid & req[cand];
            idx   = hit ? cand : idx;
            valid = valid | hit;
        end
    end

endmodule

// File: rtl/dma_axis_rr_arbiter.sv
// N-channel AXI4-Stream packet arbiter: packet-granular round-robin, a
// registered output stage, optional source-channel tag in TUSER and a
// wrapping completed-packet counter per channel.
module dma_axis_rr_arbiter
    import dma_axis_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 256,
    parameter int C_TUSER_WIDTH = TUSER_WIDTH_DEFAULT,
    parameter int C_NUM_CH      = 4,
    parameter int C_TAG_EN      = 1,
    parameter int C_TAG_LSB     = TAG_LSB_DEFAULT
) (
    input  logic                          AXIS_ACLK,
    input  logic                          AXIS_ARESETN,
    dma_axis_rr_arbiter_if.slave          axis,
    output logic [C_NUM_CH*CNT_WIDTH-1:0] PKT_CNT
);

    localparam int CHW = clog2(C_NUM_CH);
    localparam int SW  = C_DATA_WIDTH / 8;

    arb_state_e               state_r, state_nxt_s;
    logic [CHW-1:0]           gnt_r, gnt_nxt_s;
    logic [CHW-1:0]           last_gnt_r, last_gnt_nxt_s;
    logic                     pick_valid_s;
    logic [CHW-1:0]           pick_idx_s;
    logic                     ready_s;
    logic                     accept_s;
    logic                     pkt_done_s;
    logic [C_NUM_CH-1:0]      s_tready_s;

    logic [C_DATA_WIDTH-1:0]  sel_tdata_s;
    logic [SW-1:0]            sel_tstrb_s;
    logic [C_TUSER_WIDTH-1:0] sel_tuser_s;
    logic [C_TUSER_WIDTH-1:0] tag_tuser_s;
    logic                     sel_tlast_s;

    logic [C_DATA_WIDTH-1:0]  m_tdata_r;
    logic [SW-1:0]            m_tstrb_r;
    logic [C_TUSER_WIDTH-1:0] m_tuser_r;
    logic                     m_tvalid_r;
    logic                     m_tlast_r;

    dma_axis_rr_pick #(
        .C_NUM_CH (C_NUM_CH),
        .CHW      (CHW)
    ) u_pick (
        .req      (axis.S_AXIS_TVALID),
        .last_gnt (last_gnt_r),
        .valid    (pick_valid_s),
        .idx      (pick_idx_s)
    );

    // Only the granted channel sees ready, and only when the output slot frees.
    assign ready_s    = (state_r == BUSY) & (~m_tvalid_r | axis.M_AXIS_TREADY);
    assign accept_s   = ready_s & axis.S_AXIS_TVALID[gnt_r];
    assign pkt_done_s = accept_s & sel_tlast_s;

    // Granted channel's slices of the packed slave buses.
    assign sel_tdata_s = axis.S_AXIS_TDATA[int'(gnt_r)*C_DATA_WIDTH +: C_DATA_WIDTH];
    assign sel_tstrb_s = axis.S_AXIS_TSTRB[int'(gnt_r)*SW +: SW];
    assign sel_tuser_s = axis.S_AXIS_TUSER[int'(gnt_r)*C_TUSER_WIDTH +: C_TUSER_WIDTH];
    assign sel_tlast_s = axis.S_AXIS_TLAST[gnt_r];

    generate
        if (C_TAG_EN != 0) begin : g_tag
            // Overwrite only the tag field with the source channel index.
            always_comb begin
                tag_tuser_s                  = sel_tuser_s;
                tag_tuser_s[C_TAG_LSB +: CHW] = gnt_r;
            end
        end else begin : g_no_tag
            assign tag_tuser_s = sel_tuser_s;
        end
    endgenerate

    // Per-channel ready vector; a single bit at most is ever set.
    always_comb begin
        s_tready_s        = {C_NUM_CH{1'b0}};
        s_tready_s[gnt_r] = ready_s;
    end

    assign axis.S_AXIS_TREADY = s_tready_s;

    // FSM state and grant registers.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_r    <= IDLE;
            gnt_r      <= {CHW{1'b0}};
            last_gnt_r <= CHW'(C_NUM_CH - 1);
        end else begin
            state_r    <= state_nxt_s;
            gnt_r      <= gnt_nxt_s;
            last_gnt_r <= last_gnt_nxt_s;
        end
    end

    // Next state: grant in IDLE, release the grant on the accepted TLAST beat.
    always_comb begin
        state_nxt_s    = state_r;
        gnt_nxt_s      = gnt_r;
        last_gnt_nxt_s = last_gnt_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s    = BUSY;
                    gnt_nxt_s      = pick_idx_s;
                    last_gnt_nxt_s = pick_idx_s;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            BUSY: begin
                if (pkt_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output register: load on accept, drain on downstream ready, else hold.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            m_tdata_r  <= {C_DATA_WIDTH{1'b0}};
            m_tstrb_r  <= {SW{1'b0}};
            m_tuser_r  <= {C_TUSER_WIDTH{1'b0}};
            m_tlast_r  <= 1'b0;
            m_tvalid_r <= 1'b0;
        end else if (accept_s) begin
            m_tdata_r  <= sel_tdata_s;
            m_tstrb_r  <= sel_tstrb_s;
            m_tuser_r  <= tag_tuser_s;
            m_tlast_r  <= sel_tlast_s;
            m_tvalid_r <= 1'b1;
        end else if (axis.M_AXIS_TREADY) begin
            m_tvalid_r <= 1'b0;
        end
    end

    assign axis.M_AXIS_TDATA  = m_tdata_r;
    assign axis.M_AXIS_TSTRB  = m_tstrb_r;
    assign axis.M_AXIS_TUSER  = m_tuser_r;
    assign axis.M_AXIS_TLAST  = m_tlast_r;
    assign axis.M_AXIS_TVALID = m_tvalid_r;

    generate
        for (genvar gi = 0; gi < C_NUM_CH; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_r;

            // Completed-packet counter for this channel; wraps silently.
            always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
                if (!AXIS_ARESETN) begin
                    cnt_r <= {CNT_WIDTH{1'b0}};
                end else if (pkt_done_s && (gnt_r == CHW'(gi))) begin
                    cnt_r <= cnt_r + 32'd1;
                end
            end

            assign PKT_CNT[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_r;
        end
    endgenerate

endmodule

// File: tb/tb_dma_axis_rr_arbiter.sv
// Directed bench for dma_axis_rr_arbiter: per-channel packet sources, a
// scoreboard of expected merged beats in grant order, and cycle-level checks.
module tb_dma_axis_rr_arbiter;
    import dma_axis_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 256;
    localparam int UW  = 128;
    localparam int SW  = DW / 8;
    localparam int TAG = 120;

    typedef struct {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [NCH*32-1:0] pkt_cnt;

    dma_axis_rr_arbiter_if #(.C_DATA_WIDTH(DW), .C_TUSER_WIDTH(UW), .C_NUM_CH(NCH)) axis ();

    dma_axis_rr_arbiter #(
        .C_DATA_WIDTH (DW),
        .C_TUSER_WIDTH(UW),
        .C_NUM_CH     (NCH),
        .C_TAG_EN     (1),
        .C_TAG_LSB    (TAG)
    ) dut (
        .AXIS_ACLK   (clk),
        .AXIS_ARESETN(rst_n),
        .axis        (axis),
        .PKT_CNT     (pkt_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int plen[NCH], npk[NCH], pk[NCH], bt[NCH], base[NCH];
    bit hold[NCH];
    bit bp_mode, gap_chk, stalled_prev;
    int last_macc;
    logic [3:0]    bp_pat = 4'b1001;
    logic [DW-1:0] prev_data;
    logic [UW-1:0] prev_user;
    logic          prev_last;
    beat_t exp_q[$];

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [UW-1:0] user_of(input int ch);
        return ~UW'(ch);
    endfunction

    function automatic logic [SW-1:0] strb_of(input int ch);
        return SW'(32'h8000_0000 | (32'h1 << ch));
    endfunction

    function automatic bit srcs_busy();
        bit b = 1'b0;
        for (int i = 0; i < NCH; i++) b |= (pk[i] < npk[i]);
        return b;
    endfunction

    task automatic drive_srcs();
        for (int i = 0; i < NCH; i++) begin
            axis.S_AXIS_TVALID[i]          = (pk[i] < npk[i]) && !hold[i];
            axis.S_AXIS_TDATA[i*DW +: DW]  = DW'(base[i] + pk[i]*16 + bt[i]);
            axis.S_AXIS_TSTRB[i*SW +: SW]  = strb_of(i);
            axis.S_AXIS_TUSER[i*UW +: UW]  = user_of(i);
            axis.S_AXIS_TLAST[i]           = (bt[i] == plen[i] - 1);
        end
    endtask

    task automatic push_pkt(input int ch, input int p);
        beat_t e;
        for (int b = 0; b < plen[ch]; b++) begin
            e.d = DW'(base[ch] + p*16 + b);
            e.s = strb_of(ch);
            e.u = user_of(ch);
            e.u[TAG +: 2] = 2'(ch);
            e.l = (b == plen[ch] - 1);
            exp_q.push_back(e);
        end
    endtask

    // One clock: sample handshakes at negedge, advance sources after posedge.
    task automatic step();
        logic [NCH-1:0] sacc;
        logic           macc;
        beat_t          e;
        @(negedge clk);
        sacc = axis.S_AXIS_TVALID & axis.S_AXIS_TREADY;
        macc = axis.M_AXIS_TVALID & axis.M_AXIS_TREADY;
        chk("tready_onehot", ($countones(axis.S_AXIS_TREADY) <= 1), 1'b1);
        if (stalled_prev) begin
            chk("stall_valid", axis.M_AXIS_TVALID, 1'b1);
            chk("stall_data", axis.M_AXIS_TDATA, prev_data);
            chk("stall_user", axis.M_AXIS_TUSER, prev_user);
            chk("stall_last", axis.M_AXIS_TLAST, prev_last);
        end
        if (bp_mode && axis.M_AXIS_TVALID && !axis.M_AXIS_TREADY)
            chk("bp_sready_full", axis.S_AXIS_TREADY, 4'b0000);
        stalled_prev = axis.M_AXIS_TVALID & ~axis.M_AXIS_TREADY;
        prev_data    = axis.M_AXIS_TDATA;
        prev_user    = axis.M_AXIS_TUSER;
        prev_last    = axis.M_AXIS_TLAST;
        if (macc) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", axis.M_AXIS_TDATA, 256'h0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", axis.M_AXIS_TDATA, e.d);
                chk("sb_strb", axis.M_AXIS_TSTRB, e.s);
                chk("sb_user", axis.M_AXIS_TUSER, e.u);
                chk("sb_last", axis.M_AXIS_TLAST, e.l);
            end
            if (gap_chk && last_macc >= 0) chk("pkt_gap", cyc - last_macc, 2);
            last_macc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NCH; i++) begin
            if (sacc[i]) begin
                bt[i]++;
                if (bt[i] == plen[i]) begin
                    bt[i] = 0;
                    pk[i]++;
                end
            end
        end
        axis.M_AXIS_TREADY = bp_mode ? bp_pat[cyc % 4] : 1'b1;
        drive_srcs();
    endtask

    task automatic run_until_done(input int maxc);
        int n = 0;
        while ((srcs_busy() || exp_q.size() != 0 || axis.M_AXIS_TVALID) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_timeout", (n < maxc), 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            plen[i] = 1; npk[i] = 0; pk[i] = 0; bt[i] = 0; base[i] = 0; hold[i] = 1'b0;
        end
        exp_q.delete();
        bp_mode = 1'b0; gap_chk = 1'b0; stalled_prev = 1'b0; last_macc = -1;
        axis.M_AXIS_TREADY = 1'b1;
        drive_srcs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, sampled while reset is held.
        for (int i = 0; i < NCH; i++) begin
            plen[i] = 1; npk[i] = 0; pk[i] = 0; bt[i] = 0; base[i] = 0; hold[i] = 1'b0;
        end
        axis.M_AXIS_TREADY = 1'b1;
        drive_srcs();
        #12;
        chk("rst_tvalid", axis.M_AXIS_TVALID, 1'b0);
        chk("rst_tdata", axis.M_AXIS_TDATA, 256'h0);
        chk("rst_tuser", axis.M_AXIS_TUSER, 128'h0);
        chk("rst_tlast", axis.M_AXIS_TLAST, 1'b0);
        chk("rst_sready", axis.S_AXIS_TREADY, 4'b0000);
        chk("rst_pkt_cnt", pkt_cnt, 128'h0);

        // Single 3-beat packet on channel 2.
        do_reset();
        plen[2] = 3; npk[2] = 1; base[2] = 32'hA1;
        push_pkt(2, 0);
        drive_srcs();
        step();
        chk("single_lat1_valid", axis.M_AXIS_TVALID, 1'b0);
        step();
        chk("single_lat2_valid", axis.M_AXIS_TVALID, 1'b1);
        chk("single_lat2_data", axis.M_AXIS_TDATA, 256'hA1);
        chk("single_tag", axis.M_AXIS_TUSER[TAG +: 2], 2'd2);
        run_until_done(20);
        chk("single_pkt_cnt", pkt_cnt, {32'd0, 32'd1, 32'd0, 32'd0});

        // Fairness: all channels send two 1-beat packets each.
        do_reset();
        for (int i = 0; i < NCH; i++) begin
            plen[i] = 1; npk[i] = 2; base[i] = 256 * (i + 1);
        end
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < NCH; c++) push_pkt(c, p);
        gap_chk = 1'b1;
        drive_srcs();
        run_until_done(60);
        chk("fair_pkt_cnt", pkt_cnt, {32'd2, 32'd2, 32'd2, 32'd2});

        // Backpressure: 4-beat packet on channel 1, downstream ready 1,0,0,1.
        do_reset();
        plen[1] = 4; npk[1] = 1; base[1] = 32'h10;
        push_pkt(1, 0);
        bp_mode = 1'b1;
        drive_srcs();
        run_until_done(60);
        chk("bp_pkt_cnt", pkt_cnt, {32'd0, 32'd0, 32'd1, 32'd0});

        // No preemption: ch3 pauses mid-packet while ch0 requests.
        do_reset();
        plen[3] = 4; npk[3] = 1; base[3] = 32'h30;
        plen[0] = 1; base[0] = 32'h50;
        push_pkt(3, 0);
        push_pkt(0, 0);
        drive_srcs();
        for (int n = 0; n < 20 && bt[3] < 2; n++) step();
        chk("np_reached_beat2", bt[3], 2);
        hold[3] = 1'b1; npk[0] = 1;
        drive_srcs();
        for (int h = 0; h < 5; h++) begin
            step();
            chk("np_ch0_not_ready", axis.S_AXIS_TREADY[0], 1'b0);
            if (h >= 1) chk("np_output_stalled", axis.M_AXIS_TVALID, 1'b0);
        end
        hold[3] = 1'b0;
        drive_srcs();
        run_until_done(40);
        chk("np_pkt_cnt", pkt_cnt, {32'd1, 32'd0, 32'd0, 32'd1});

        // Counter wrap on channel 0.
        do_reset();
        force dut.g_cnt[0].cnt_r = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.g_cnt[0].cnt_r;
        chk("wrap_preload", pkt_cnt[31:0], 32'hFFFF_FFFF);
        plen[0] = 2; npk[0] = 1; base[0] = 32'h60;
        push_pkt(0, 0);
        drive_srcs();
        run_until_done(20);
        chk("wrap_pkt_cnt", pkt_cnt, 128'h0);

        // Asynchronous reset on beat 2 of a 4-beat packet on channel 2.
        do_reset();
        plen[2] = 4; npk[2] = 1; base[2] = 32'h70;
        drive_srcs();
        for (int n = 0; n < 20 && bt[2] < 1; n++) step();
        chk("mid_rst_reached", bt[2], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", axis.M_AXIS_TVALID, 1'b0);
        chk("mid_rst_tdata", axis.M_AXIS_TDATA, 256'h0);
        chk("mid_rst_tuser", axis.M_AXIS_TUSER, 128'h0);
        chk("mid_rst_tlast", axis.M_AXIS_TLAST, 1'b0);
        chk("mid_rst_sready", axis.S_AXIS_TREADY, 4'b0000);
        do_reset();
        plen[0] = 1; npk[0] = 1; base[0] = 32'h80;
        plen[2] = 1; npk[2] = 1; base[2] = 32'h90;
        push_pkt(0, 0);
        push_pkt(2, 0);
        drive_srcs();
        run_until_done(20);
        chk("mid_rst_pkt_cnt", pkt_cnt, {32'd0, 32'd1, 32'd0, 32'd1});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
